// File: rtl/except_ctrl_pkg.sv
// Shared exception codes, raw flag positions, CP0 addresses and field indices
// for the MEM-stage exception controller and its CP0 forwarding logic.
package except_ctrl_pkg;

   localparam logic [31:0] EXC_VECTOR   = 32'h0000_0020;

   localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
   localparam logic [31:0] EXC_INT      = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
   localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
   localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

   localparam int FLAG_SYSCALL  = 8;
   localparam int FLAG_INVALID  = 9;
   localparam int FLAG_TRAP     = 10;
   localparam int FLAG_OVERFLOW = 11;
   localparam int FLAG_ERET     = 12;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int IM_LO      = 8;
   localparam int IM_HI      = 15;
   localparam int IP_LO      = 8;
   localparam int IP_HI      = 15;

   typedef enum logic {ST_RUN, ST_TAKE} state_t;

   // Highest-priority source wins; order is interrupt, syscall, invalid, trap, overflow, eret.
   function automatic logic [31:0] exc_select(input logic int_pend, input logic [31:0] flags);
      logic [31:0] code;
      code = EXC_NONE;
      if (int_pend)                 code = EXC_INT;
      else if (flags[FLAG_SYSCALL])  code = EXC_SYSCALL;
      else if (flags[FLAG_INVALID])  code = EXC_INVALID;
      else if (flags[FLAG_TRAP])     code = EXC_TRAP;
      else if (flags[FLAG_OVERFLOW]) code = EXC_OVERFLOW;
      else if (flags[FLAG_ERET])     code = EXC_ERET;
      return code;
   endfunction

endpackage

// File: rtl/except_ctrl_cp0_bypass.sv
// Forwards an in-flight WB mtc0 onto Status/Cause/EPC; purely combinational, no backpressure.
// Cause takes only its software-writable bits [9:8], [22], [23] from the WB data.
module except_ctrl_cp0_bypass
   import except_ctrl_pkg::*;
(
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] status_eff,
   output logic [31:0] cause_eff,
   output logic [31:0] epc_eff
);

   always_comb begin
      status_eff = cp0_status_i;
      cause_eff  = cp0_cause_i;
      epc_eff    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         if (wb_cp0_waddr_i == CP0_STATUS) status_eff = wb_cp0_data_i;
         if (wb_cp0_waddr_i == CP0_EPC)    epc_eff    = wb_cp0_data_i;
         if (wb_cp0_waddr_i == CP0_CAUSE) begin
            cause_eff[9:8] = wb_cp0_data_i[9:8];
            cause_eff[22]  = wb_cp0_data_i[22];
            cause_eff[23]  = wb_cp0_data_i[23];
         end
      end
   end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: cancel is combinational in the detect cycle, code/PC/flush registered one cycle later.
// A stall or bubble holds the exception off; the instruction in MEM during the flush cycle is never taken.
module except_ctrl
   import except_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [31:0] mem_except_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic        cancel_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   state_t      state, state_nxt;
   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_pend, detect_en;
   logic [31:0] code;
   logic [31:0] exc_nxt, addr_nxt, pc_nxt;
   logic        ds_nxt, flush_nxt;
   logic        unused_bits;

   except_ctrl_cp0_bypass u_cp0_bypass (
      .cp0_status_i   (cp0_status_i),
      .cp0_cause_i    (cp0_cause_i),
      .cp0_epc_i      (cp0_epc_i),
      .wb_cp0_we_i    (wb_cp0_we_i),
      .wb_cp0_waddr_i (wb_cp0_waddr_i),
      .wb_cp0_data_i  (wb_cp0_data_i),
      .status_eff     (status_eff),
      .cause_eff      (cause_eff),
      .epc_eff        (epc_eff)
   );

   assign int_pend  = (|(status_eff[IM_HI:IM_LO] & cause_eff[IP_HI:IP_LO]))
                      && !status_eff[STATUS_EXL] && status_eff[STATUS_IE];
   assign detect_en = !rst && (state == ST_RUN) && !stall_i && mem_valid_i;
   assign code      = exc_select(int_pend, mem_except_i);

   assign unused_bits = ^{status_eff, cause_eff, mem_except_i};

   always_comb begin
      state_nxt = state;
      cancel_o  = 1'b0;
      exc_nxt   = EXC_NONE;
      addr_nxt  = 32'h0;
      ds_nxt    = 1'b0;
      flush_nxt = 1'b0;
      pc_nxt    = 32'h0;
      case (state)
         ST_RUN: begin
            if (detect_en && (code != EXC_NONE)) begin
               cancel_o  = 1'b1;
               exc_nxt   = code;
               addr_nxt  = mem_pc_i;
               ds_nxt    = mem_in_delayslot_i;
               flush_nxt = 1'b1;
               pc_nxt    = (code == EXC_ERET) ? epc_eff : EXC_VECTOR;
               state_nxt = ST_TAKE;
            end
         end
         ST_TAKE: state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ST_RUN;
         excepttype_o        <= EXC_NONE;
         current_inst_addr_o <= 32'h0;
         is_in_delayslot_o   <= 1'b0;
         flush_o             <= 1'b0;
         new_pc_o            <= 32'h0;
      end else begin
         state               <= state_nxt;
         excepttype_o        <= exc_nxt;
         current_inst_addr_o <= addr_nxt;
         is_in_delayslot_o   <= ds_nxt;
         flush_o             <= flush_nxt;
         new_pc_o            <= pc_nxt;
      end
   end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: inputs change 1 time unit after each rising edge,
// cancel is checked in the same cycle, registered outputs after the next edge.
module tb_except_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_delayslot_i;
   logic [31:0] mem_except_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic        cancel_o;
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   int checks = 0;
   int errors = 0;
   int flush_count;

   except_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .stall_i             (stall_i),
      .mem_valid_i         (mem_valid_i),
      .mem_pc_i            (mem_pc_i),
      .mem_in_delayslot_i  (mem_in_delayslot_i),
      .mem_except_i        (mem_except_i),
      .cp0_status_i        (cp0_status_i),
      .cp0_cause_i         (cp0_cause_i),
      .cp0_epc_i           (cp0_epc_i),
      .wb_cp0_we_i         (wb_cp0_we_i),
      .wb_cp0_waddr_i      (wb_cp0_waddr_i),
      .wb_cp0_data_i       (wb_cp0_data_i),
      .cancel_o            (cancel_o),
      .excepttype_o        (excepttype_o),
      .current_inst_addr_o (current_inst_addr_o),
      .is_in_delayslot_o   (is_in_delayslot_o),
      .flush_o             (flush_o),
      .new_pc_o            (new_pc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_i = 0; mem_valid_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0; mem_except_i = 0;
      cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
      wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [31:0] flags, input logic ds);
      mem_valid_i = 1; mem_pc_i = pc; mem_except_i = flags; mem_in_delayslot_i = ds;
   endtask

   // One detect + take sequence checking code and redirect target.
   task automatic take(input string tag, input logic [31:0] flags, input logic [31:0] exp_code,
                       input logic [31:0] exp_pc);
      instr(32'h0000_4000, flags, 1'b0);
      #1 chk({tag, "_cancel"}, {31'b0, cancel_o}, 32'd1);
      tick();
      idle();
      chk({tag, "_code"}, excepttype_o, exp_code);
      chk({tag, "_newpc"}, new_pc_o, exp_pc);
      tick();
   endtask

   initial begin
      idle();
      rst = 1;
      instr(32'h0000_1000, 32'h100, 1'b0);
      #1 chk("rst_cancel", {31'b0, cancel_o}, 32'd0);
      tick();
      tick();
      chk("rst_flush", {31'b0, flush_o}, 32'd0);
      chk("rst_code", excepttype_o, 32'h0);
      chk("rst_newpc", new_pc_o, 32'h0);
      rst = 0;
      idle();
      tick();

      // Syscall, not stalled
      instr(32'h0000_1000, 32'h100, 1'b0);
      #1 chk("sys_cancel", {31'b0, cancel_o}, 32'd1);
      tick();
      idle();
      chk("sys_code", excepttype_o, 32'h8);
      chk("sys_addr", current_inst_addr_o, 32'h1000);
      chk("sys_ds", {31'b0, is_in_delayslot_o}, 32'd0);
      chk("sys_flush", {31'b0, flush_o}, 32'd1);
      chk("sys_newpc", new_pc_o, 32'h20);
      tick();
      chk("sys_n2_code", excepttype_o, 32'h0);
      chk("sys_n2_addr", current_inst_addr_o, 32'h0);
      chk("sys_n2_flush", {31'b0, flush_o}, 32'd0);
      chk("sys_n2_newpc", new_pc_o, 32'h0);

      // Interrupt beats overflow
      cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
      instr(32'h0000_2000, 32'h800, 1'b1);
      #1 chk("int_cancel", {31'b0, cancel_o}, 32'd1);
      tick();
      idle();
      chk("int_code", excepttype_o, 32'h1);
      chk("int_ds", {31'b0, is_in_delayslot_o}, 32'd1);
      chk("int_addr", current_inst_addr_o, 32'h2000);
      chk("int_newpc", new_pc_o, 32'h20);
      tick();

      // eret with EPC forwarded from WB; a syscall arriving during TAKE is ignored
      cp0_epc_i = 32'h0; wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h2468;
      instr(32'h0000_3000, 32'h1000, 1'b0);
      tick();
      idle();
      instr(32'h0000_3004, 32'h100, 1'b0);
      #1 chk("eret_code", excepttype_o, 32'he);
      chk("eret_newpc", new_pc_o, 32'h2468);
      chk("eret_flush", {31'b0, flush_o}, 32'd1);
      chk("b2b_cancel", {31'b0, cancel_o}, 32'd0);
      tick();
      idle();
      chk("b2b_flush", {31'b0, flush_o}, 32'd0);
      chk("b2b_code", excepttype_o, 32'h0);
      tick();

      // Priority ladder, ignored flag bits, eret from CP0 EPC with unrelated WB write
      take("pri_sys", 32'h700, 32'h8, 32'h20);
      take("pri_inv", 32'h600, 32'ha, 32'h20);
      take("pri_trap", 32'hc00, 32'hd, 32'h20);
      take("pri_ovf", 32'h1800, 32'hc, 32'h20);
      instr(32'h0000_5000, 32'hffff_e0ff, 1'b0);
      #1 chk("ignored_cancel", {31'b0, cancel_o}, 32'd0);
      tick();
      chk("ignored_flush", {31'b0, flush_o}, 32'd0);
      cp0_epc_i = 32'h3000; wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h5555;
      take("eret_cp0", 32'h1000, 32'he, 32'h3000);

      // Stall hold
      flush_count = 0;
      stall_i = 1;
      instr(32'h0000_6000, 32'h100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_cancel", {31'b0, cancel_o}, 32'd0);
         tick();
         if (flush_o) flush_count++;
      end
      stall_i = 0;
      #1 chk("unstall_cancel", {31'b0, cancel_o}, 32'd1);
      tick();
      if (flush_o) flush_count++;
      chk("unstall_addr", current_inst_addr_o, 32'h6000);
      idle();
      tick();
      if (flush_o) flush_count++;
      chk("stall_flush_count", flush_count, 32'd1);

      // Interrupt pending during bubbles
      cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
      for (int i = 0; i < 2; i++) begin
         #1 chk("bubble_cancel", {31'b0, cancel_o}, 32'd0);
         tick();
         chk("bubble_flush", {31'b0, flush_o}, 32'd0);
      end
      instr(32'h0000_7000, 32'h0, 1'b0);
      #1 chk("bubble_valid_cancel", {31'b0, cancel_o}, 32'd1);
      tick();
      idle();
      chk("bubble_code", excepttype_o, 32'h1);
      tick();

      // EXL set blocks interrupts
      cp0_status_i = 32'h0000_0403; cp0_cause_i = 32'h0000_0400;
      instr(32'h0000_7100, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("exl_cancel", {31'b0, cancel_o}, 32'd0);
         tick();
         chk("exl_flush", {31'b0, flush_o}, 32'd0);
      end

      // WB mtc0 Status clearing IE suppresses the interrupt
      cp0_status_i = 32'h0000_0401; wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h400;
      #1 chk("ie_bypass_cancel", {31'b0, cancel_o}, 32'd0);
      tick();
      chk("ie_bypass_flush", {31'b0, flush_o}, 32'd0);

      // Cause forwarding: IP bit 10 is not writable, IP bit 8 is
      cp0_status_i = 32'h0000_0501; cp0_cause_i = 32'h0; wb_cp0_waddr_i = 5'd13;
      wb_cp0_data_i = 32'h400;
      #1 chk("cause_ip10_cancel", {31'b0, cancel_o}, 32'd0);
      tick();
      wb_cp0_data_i = 32'h100;
      #1 chk("cause_ip8_cancel", {31'b0, cancel_o}, 32'd1);
      tick();
      idle();
      chk("cause_ip8_code", excepttype_o, 32'h1);
      tick();

      // Reset asserted in TAKE, with a second flag present
      instr(32'h0000_8000, 32'h100, 1'b0);
      tick();
      rst = 1;
      instr(32'h0000_8004, 32'h400, 1'b0);
      #1 chk("rst_take_flush_now", {31'b0, flush_o}, 32'd1);
      chk("rst_take_cancel", {31'b0, cancel_o}, 32'd0);
      tick();
      chk("rst_take_flush", {31'b0, flush_o}, 32'd0);
      chk("rst_take_code", excepttype_o, 32'h0);
      rst = 0;
      idle();
      tick();
      chk("rst_take_second", {31'b0, flush_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
